// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests words from instruction memory and feeds the
// decoder through a 2-entry FIFO. Redirect flushes the buffer and restarts fetch.
//
//   state | meaning
//   START | out of reset, no request yet
//   FETCH | request outstanding at fetch_pc
//   FULL  | buffer holds two entries, request paused
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [3:0]  opcode,
  output logic [11:0] operand,
  output logic [15:0] instr_pc
);

  typedef enum logic [1:0] {START, FETCH, FULL} state_t;

  state_t      state;
  logic [15:0] fetch_pc;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic        head;
  logic        tail;
  logic [31:0] buf_q [2];
  logic [31:0] head_entry;
  logic        ack_ok;
  logic        pop;

  // Redirect masks both the ack and the pop for the cycle it is asserted.
  assign ack_ok = imem_req & imem_ack & ~redirect;
  assign pop    = instr_valid & instr_ready & ~redirect;

  always_comb begin
    count_nxt = count;
    if (ack_ok && !pop)
      count_nxt = count + 2'd1;
    else if (pop && !ack_ok)
      count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= START;
      imem_req <= 1'b0;
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
      head     <= 1'b0;
      tail     <= 1'b0;
    end else if (redirect) begin
      state    <= FETCH;
      imem_req <= 1'b1;
      fetch_pc <= redirect_pc;
      count    <= 2'd0;
      head     <= 1'b0;
      tail     <= 1'b0;
    end else begin
      if (ack_ok) begin
        tail     <= ~tail;
        fetch_pc <= fetch_pc + 16'd1;
      end
      if (pop)
        head <= ~head;
      count <= count_nxt;
      case (state)
        START: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (count_nxt == 2'd2) begin
            state    <= FULL;
            imem_req <= 1'b0;
          end
        end
        FULL: begin
          if (count_nxt < 2'd2) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= START;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (ack_ok)
      buf_q[tail] <= {imem_rdata, fetch_pc};
  end

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != 2'd0);
  assign head_entry  = buf_q[head];
  assign opcode      = instr_valid ? head_entry[31:28] : 4'h0;
  assign operand     = instr_valid ? head_entry[27:16] : 12'h000;
  assign instr_pc    = instr_valid ? head_entry[15:0]  : 16'h0000;

endmodule
